frame_filler_pp: RTL and testbench

//  Parametrised successor of the telemetry frame filler. Buffers incoming sensor words in an internal FIFO.

---
 rtl/frame_filler_pp_if.sv | 12 +
 rtl/frame_filler_pp.sv | 174 +++++++++++++++++
 tb/tb_frame_filler_pp.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_filler_pp_if.sv
// RAM write port of the frame filler: registered {bank, offset} address, {parity, payload} data, 1-clk strobe.
interface frame_filler_pp_if #(
  parameter int OUT_W  = 12,
  parameter int ADDR_W = 10
);
  logic [OUT_W-1:0]  outWDAT;
  logic [ADDR_W-1:0] outWADR;
  logic              outWREN;

  modport master (output outWDAT, outWADR, outWREN);
  modport slave  (input  outWDAT, outWADR, outWREN);
endinterface

// File: rtl/frame_filler_pp.sv
// Telemetry frame filler: FIFO-buffered sensor words packed into ping-pong RAM frames,
// each frame led by a phase-rotated sync marker, every word carrying odd parity.
//
// state  | meaning
// IDLE   | after reset, waiting for the first bank switch
// MARK   | writing the MARK_WORDS sync-marker words
// DATA   | writing FIFO words until offset FRAME_LEN-1 has been strobed
// DONE   | frame complete, no writes until the next bank switch
module frame_filler_pp #(
  parameter int DATA_W     = 16,
  parameter int OUT_W      = 12,
  parameter int ADDR_W     = 10,
  parameter int FRAME_LEN  = 512,
  parameter int MARK_WORDS = 4,
  parameter logic [MARK_WORDS*(OUT_W-1)-1:0] SYNC = 44'hF9A42BB1F35,
  parameter int M_BITS     = 31,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] word,
  input  logic              ready,
  input  logic              bufSwitch,
  frame_filler_pp_if.master ram,
  output logic              fifoOvf,
  output logic              frameUnd,
  output logic              frameDone,
  output logic [1:0]        phase
);
  localparam int PAY_W  = OUT_W - 1;
  localparam int OFF_W  = ADDR_W - 1;
  localparam int SYNC_W = MARK_WORDS * PAY_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [SYNC_W-1:0] M_MASK = ~({SYNC_W{1'b1}} >> M_BITS);

  typedef enum logic [1:0] {S_IDLE, S_MARK, S_DATA, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        rdy_sync_q, rdy_sync_d, bsw_sync_q, bsw_sync_d;
  logic [PAY_W-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bank_q, bank_d, pend_q, pend_d, wren_q, wren_d;
  logic [1:0]        phase_q, phase_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [OUT_W-1:0]  dat_q, dat_d;
  logic              ovf_q, ovf_d, und_q, und_d, done_q, done_d;
  logic              rdy_edge, bsw_edge, fifo_full, fifo_empty, push_ok, pop;
  logic [SYNC_W-1:0] sync_ph;
  logic [PAY_W-1:0]  mark_pay, fifo_head;
  logic              unused_word_hi;

  assign unused_word_hi = ^word[DATA_W-1:PAY_W];

  assign rdy_sync_d = {rdy_sync_q[1:0], ready};
  assign bsw_sync_d = {bsw_sync_q[1:0], bufSwitch};
  assign rdy_edge   = rdy_sync_q[1] & ~rdy_sync_q[2];
  assign bsw_edge   = bsw_sync_q[1] & ~bsw_sync_q[2];

  assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign fifo_head  = fifo_mem_q[rd_ptr_q];
  // A full FIFO still accepts a word when the same cycle pops one.
  assign push_ok    = rdy_edge & (~fifo_full | pop);

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    ovf_d    = ovf_q | (rdy_edge & fifo_full & ~pop);
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // phase[0] flips the M field, phase[1] flips the B field.
  assign sync_ph  = SYNC ^ ({SYNC_W{phase_q[0]}} & M_MASK) ^ ({SYNC_W{phase_q[1]}} & ~M_MASK);
  assign mark_pay = PAY_W'(sync_ph >> (PAY_W * (MARK_WORDS - 1 - int'(off_q))));

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    phase_d = phase_q;
    off_d   = off_q;
    pend_d  = pend_q;
    wren_d  = 1'b0;
    adr_d   = adr_q;
    dat_d   = dat_q;
    und_d   = und_q;
    done_d  = done_q;
    pop     = 1'b0;
    if (bsw_edge) begin
      bank_d  = ~bank_q;
      phase_d = phase_q + 2'd1;
      off_d   = '0;
      state_d = S_MARK;
      pend_d  = 1'b0;
      done_d  = 1'b0;
      if (state_q == S_MARK || state_q == S_DATA) und_d = 1'b1;
    end else if (pend_q) begin
      wren_d = 1'b1;
      pend_d = 1'b0;
      if (state_q == S_DATA && off_q == OFF_W'(FRAME_LEN - 1)) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else begin
        off_d = off_q + OFF_W'(1);
        if (state_q == S_MARK && off_q == OFF_W'(MARK_WORDS - 1)) state_d = S_DATA;
      end
    end else if (state_q == S_MARK) begin
      adr_d  = {bank_q, off_q};
      dat_d  = {~^mark_pay, mark_pay};
      pend_d = 1'b1;
    end else if (state_q == S_DATA && !fifo_empty) begin
      pop    = 1'b1;
      adr_d  = {bank_q, off_q};
      dat_d  = {~^fifo_head, fifo_head};
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= word[PAY_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rdy_sync_q <= '0;
      bsw_sync_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      bank_q     <= 1'b0;
      phase_q    <= 2'd0;
      off_q      <= '0;
      pend_q     <= 1'b0;
      wren_q     <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      ovf_q      <= 1'b0;
      und_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_sync_q <= rdy_sync_d;
      bsw_sync_q <= bsw_sync_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      bank_q     <= bank_d;
      phase_q    <= phase_d;
      off_q      <= off_d;
      pend_q     <= pend_d;
      wren_q     <= wren_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      ovf_q      <= ovf_d;
      und_q      <= und_d;
      done_q     <= done_d;
    end
  end

  assign ram.outWDAT = dat_q;
  assign ram.outWADR = adr_q;
  assign ram.outWREN = wren_q;
  assign fifoOvf     = ovf_q;
  assign frameUnd    = und_q;
  assign frameDone   = done_q;
  assign phase       = phase_q;
endmodule

// File: tb/tb_frame_filler_pp.sv
// Directed bench for frame_filler_pp: markers per phase, data packing, frame end, overflow, bank switching, reset.
module tb_frame_filler_pp;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] word = '0;
  logic        ready = 1'b0;
  logic        bufSwitch = 1'b0;
  logic        fifoOvf, frameUnd, frameDone;
  logic [1:0]  phase;

  frame_filler_pp_if #(.OUT_W(12), .ADDR_W(10)) bus ();

  frame_filler_pp dut (
    .clk       (clk),
    .reset     (reset),
    .word      (word),
    .ready     (ready),
    .bufSwitch (bufSwitch),
    .ram       (bus.master),
    .fifoOvf   (fifoOvf),
    .frameUnd  (frameUnd),
    .frameDone (frameDone),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Hand-computed marker words {parity, payload}, indexed [phase][marker].
  logic [11:0] mk [4][4] = '{
    '{12'hFCD, 12'h10A, 12'h763, 12'h735},
    '{12'h032, 12'hEF5, 12'h89F, 12'h735},
    '{12'hFCD, 12'h10A, 12'h760, 12'h8CA},
    '{12'h032, 12'hEF5, 12'h89C, 12'h8CA}
  };

  logic [9:0]  s_adr [$];
  logic [11:0] s_dat [$];

  always @(negedge clk) begin
    if (reset && bus.outWREN) begin
      s_adr.push_back(bus.outWADR);
      s_dat.push_back(bus.outWDAT);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    word  = w;
    ready = 1'b1;
    cyc(3);
    ready = 1'b0;
    cyc(3);
  endtask

  task automatic bsw_pulse();
    bufSwitch = 1'b1;
    cyc(3);
    bufSwitch = 1'b0;
    cyc(3);
  endtask

  task automatic wait_strobes(input int n, input int budget);
    for (int k = 0; k < budget && s_adr.size() < n; k++) cyc(1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc(3);
    tests++;
    if ({bus.outWREN, bus.outWADR, bus.outWDAT, fifoOvf, frameUnd, frameDone, phase} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: wren=%0b adr=%h dat=%h ovf=%0b und=%0b done=%0b phase=%0d, all must be 0",
               bus.outWREN, bus.outWADR, bus.outWDAT, fifoOvf, frameUnd, frameDone, phase);
    end
    reset = 1'b1;
    cyc(10);
    tests++;
    if (s_adr.size() !== 0) begin
      fails++;
      $display("FAIL idle_no_write: %0d strobes, expected 0", s_adr.size());
    end
  endtask

  task automatic test_first_markers();
    bsw_pulse();
    wait_strobes(4, 60);
    tests++;
    if (s_adr.size() !== 4) begin
      fails++;
      $display("FAIL t1_count: %0d strobes, expected 4", s_adr.size());
    end
    for (int k = 0; k < 4 && k < s_adr.size(); k++) begin
      tests++;
      if (s_adr[k] !== 10'(10'h200 + k) || s_dat[k] !== mk[1][k]) begin
        fails++;
        $display("FAIL t1_marker%0d: adr=%h dat=%h, expected adr=%h dat=%h",
                 k, s_adr[k], s_dat[k], 10'(10'h200 + k), mk[1][k]);
      end
    end
    tests++;
    if (phase !== 2'd1) begin
      fails++;
      $display("FAIL t1_phase: %0d, expected 1", phase);
    end
  endtask

  task automatic test_data_words();
    push_word(16'h1234);
    push_word(16'h0ABC);
    wait_strobes(6, 60);
    tests++;
    if (s_adr.size() !== 6) begin
      fails++;
      $display("FAIL t2_count: %0d strobes, expected 6", s_adr.size());
    end else begin
      tests++;
      if (s_adr[4] !== 10'h204 || s_dat[4] !== 12'hA34) begin
        fails++;
        $display("FAIL t2_word0: adr=%h dat=%h, expected 204/a34", s_adr[4], s_dat[4]);
      end
      tests++;
      if (s_adr[5] !== 10'h205 || s_dat[5] !== 12'hABC) begin
        fails++;
        $display("FAIL t2_word1: adr=%h dat=%h, expected 205/abc", s_adr[5], s_dat[5]);
      end
    end
  endtask

  task automatic test_frame_fill();
    int bad_adr = 0;
    int bad_pay = 0;
    for (int i = 6; i < 512; i++) push_word(16'hF000 | 16'(i));
    wait_strobes(512, 60);
    cyc(6);
    tests++;
    if (s_adr.size() !== 512) begin
      fails++;
      $display("FAIL t3_count: %0d strobes, expected 512", s_adr.size());
    end else begin
      for (int i = 0; i < 512; i++) if (s_adr[i] !== 10'(10'h200 + i)) bad_adr++;
      for (int i = 6; i < 512; i++) if (s_dat[i][10:0] !== 11'(i)) bad_pay++;
      tests++;
      if (bad_adr !== 0) begin
        fails++;
        $display("FAIL t3_addr_seq: %0d out-of-sequence addresses, expected 0", bad_adr);
      end
      tests++;
      if (bad_pay !== 0) begin
        fails++;
        $display("FAIL t3_payload: %0d wrong payloads, expected 0", bad_pay);
      end
      tests++;
      if (s_adr[511] !== 10'h3FF || s_dat[511] !== 12'h1FF || s_dat[256] !== 12'h100) begin
        fails++;
        $display("FAIL t3_last: adr=%h dat=%h dat256=%h, expected 3ff/1ff/100",
                 s_adr[511], s_dat[511], s_dat[256]);
      end
    end
    tests++;
    if (frameDone !== 1'b1) begin
      fails++;
      $display("FAIL t3_frame_done: %0b, expected 1", frameDone);
    end
  endtask

  task automatic test_overflow();
    for (int j = 0; j < 16; j++) push_word(16'h0500 + 16'(j));
    tests++;
    if (fifoOvf !== 1'b0) begin
      fails++;
      $display("FAIL t4_ovf_at16: %0b, expected 0", fifoOvf);
    end
    push_word(16'h0510);
    cyc(4);
    tests++;
    if (fifoOvf !== 1'b1) begin
      fails++;
      $display("FAIL t4_ovf_at17: %0b, expected 1", fifoOvf);
    end
    tests++;
    if (s_adr.size() !== 512) begin
      fails++;
      $display("FAIL t4_done_no_write: %0d strobes, expected 512", s_adr.size());
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    bsw_pulse();
    wait_strobes(532, 120);
    cyc(20);
    tests++;
    if (s_adr.size() !== 532) begin
      fails++;
      $display("FAIL t5_count: %0d strobes, expected 532 (16 stored words only)", s_adr.size());
    end else begin
      for (int k = 0; k < 4; k++)
        if (s_adr[512+k] !== 10'(k) || s_dat[512+k] !== mk[2][k]) bad++;
      tests++;
      if (bad !== 0) begin
        fails++;
        $display("FAIL t5_markers_ph2: %0d wrong marker words, expected 0", bad);
      end
      bad = 0;
      for (int j = 0; j < 16; j++)
        if (s_adr[516+j] !== 10'(4 + j) || s_dat[516+j][10:0] !== 11'(11'h500 + j)) bad++;
      tests++;
      if (bad !== 0 || s_dat[516] !== 12'hD00) begin
        fails++;
        $display("FAIL t5_fifo_words: %0d wrong words, first dat=%h, expected 0 and d00", bad, s_dat[516]);
      end
    end
    tests++;
    if (frameUnd !== 1'b0 || frameDone !== 1'b0 || phase !== 2'd2) begin
      fails++;
      $display("FAIL t5_status: und=%0b done=%0b phase=%0d, expected 0/0/2", frameUnd, frameDone, phase);
    end
    for (int i = 0; i < 80; i++) push_word(16'h0600 + 16'(i));
    wait_strobes(612, 60);
    cyc(4);
    tests++;
    if (s_adr.size() !== 612 || s_adr[611] !== 10'h063) begin
      fails++;
      $display("FAIL t5_offset99: %0d strobes, expected 612 ending at 063", s_adr.size());
    end
    bsw_pulse();
    wait_strobes(616, 60);
    tests++;
    if (frameUnd !== 1'b1 || phase !== 2'd3) begin
      fails++;
      $display("FAIL t5_underrun: und=%0b phase=%0d, expected 1/3", frameUnd, phase);
    end
    bad = 0;
    for (int k = 0; k < 4 && 612 + k < s_adr.size(); k++)
      if (s_adr[612+k] !== 10'(10'h200 + k) || s_dat[612+k] !== mk[3][k]) bad++;
    tests++;
    if (bad !== 0 || s_adr.size() !== 616) begin
      fails++;
      $display("FAIL t5_markers_ph3: %0d wrong, %0d strobes, expected 0 and 616", bad, s_adr.size());
    end
  endtask

  task automatic test_phase_wrap_and_reset();
    int bad = 0;
    int n_after;
    int k;
    bsw_pulse();
    wait_strobes(620, 60);
    tests++;
    if (phase !== 2'd0) begin
      fails++;
      $display("FAIL t6_phase_wrap: %0d, expected 0", phase);
    end
    for (int m = 0; m < 4 && 616 + m < s_adr.size(); m++)
      if (s_adr[616+m] !== 10'(m) || s_dat[616+m] !== mk[0][m]) bad++;
    tests++;
    if (bad !== 0 || s_adr.size() !== 620) begin
      fails++;
      $display("FAIL t6_markers_ph0: %0d wrong, %0d strobes, expected 0 and 620", bad, s_adr.size());
    end
    word  = 16'h0123;
    ready = 1'b1;
    k = 0;
    @(negedge clk);
    while (bus.outWREN !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (bus.outWREN !== 1'b1) begin
      fails++;
      $display("FAIL t6_strobe_timeout: no strobe within 40 clk, expected one");
    end
    reset = 1'b0;
    #1;
    tests++;
    if ({bus.outWREN, bus.outWADR, bus.outWDAT, fifoOvf, frameUnd, frameDone, phase} !== '0) begin
      fails++;
      $display("FAIL t6_async_reset: wren=%0b adr=%h dat=%h ovf=%0b und=%0b done=%0b phase=%0d, all must be 0",
               bus.outWREN, bus.outWADR, bus.outWDAT, fifoOvf, frameUnd, frameDone, phase);
    end
    ready = 1'b0;
    cyc(3);
    reset = 1'b1;
    n_after = s_adr.size();
    cyc(12);
    tests++;
    if (s_adr.size() !== n_after) begin
      fails++;
      $display("FAIL t6_no_write_after_reset: %0d strobes, expected %0d", s_adr.size(), n_after);
    end
  endtask

  initial begin
    test_reset();
    test_first_markers();
    test_data_words();
    test_frame_fill();
    test_overflow();
    test_back_to_back();
    test_phase_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
